// File: rtl/axi_wr_pkg.sv
// ============================================================================
// axi_wr_pkg : burst/response encodings and FSM state type for the AXI write sink
// Revision   : 1.0
// ============================================================================
`default_nettype none

package axi_wr_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    RESP = 2'd2
  } wr_sink_state_e;

  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_beat_addr_next.sv
// ============================================================================
// axi_beat_addr_next : combinational next-beat byte address for FIXED/INCR/WRAP
// Revision           : 1.0
// ============================================================================
`default_nettype none

module axi_beat_addr_next
  import axi_wr_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] w_bytes;
  logic [AW-1:0] w_wrap_len;
  logic [AW-1:0] w_aligned;
  logic [AW-1:0] w_wrap_base;

  always_comb begin
    w_bytes     = AW'(1) << size;
    w_wrap_len  = (AW'(len) + AW'(1)) << size;
    w_aligned   = addr & ~(w_bytes - AW'(1));
    w_wrap_base = addr & ~(w_wrap_len - AW'(1));
    next_addr   = addr;
    case (burst)
      BURST_INCR: next_addr = w_aligned + w_bytes;
      BURST_WRAP: next_addr = w_wrap_base | ((addr + w_bytes) & (w_wrap_len - AW'(1)));
      default:    next_addr = addr;  // FIXED and reserved hold the address
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/axi_wr_mem_sink.sv
// ============================================================================
// axi_wr_mem_sink : AXI4 write slave driving a single-port memory write port
// Option          : AXI_WR_SINK_WLAST_CHECK_EN enables wlast mismatch -> SLVERR
// Revision        : 1.0
// ============================================================================
`default_nettype none

module axi_wr_mem_sink
  import axi_wr_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [AW-1:0]     s_axi_awaddr,
  input  logic [7:0]        s_axi_awlen,
  input  logic [2:0]        s_axi_awsize,
  input  logic [1:0]        s_axi_awburst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [DW-1:0]     s_axi_wdata,
  input  logic [DW/8-1:0]   s_axi_wstrb,
  input  logic              s_axi_wlast,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_wstrb,
  input  logic              mem_ready
);

  localparam logic [2:0] C_SIZE_MAX = 3'($clog2(DW/8));

  wr_sink_state_e r_state, w_state_next;
  logic           r_rst_done;
  logic [AW-1:0]  r_addr;
  logic [7:0]     r_len;
  logic [2:0]     r_size;
  logic [1:0]     r_burst;
  logic [7:0]     r_beat_cnt;
  logic           r_err;
  logic           w_aw_err;
  logic           w_aw_hs;
  logic           w_w_hs;
  logic           w_last_beat;
  logic           w_wlast_mm;
  logic [AW-1:0]  w_next_addr;

  assign w_aw_err = (s_axi_awburst == 2'b11) ||
                    (s_axi_awsize > C_SIZE_MAX) ||
                    ((s_axi_awburst == BURST_WRAP) && !wrap_len_ok(s_axi_awlen));

  assign w_aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_w_hs      = s_axi_wvalid && s_axi_wready;
  assign w_last_beat = (r_beat_cnt == r_len);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= IDLE;
      r_rst_done <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_rst_done <= 1'b1;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = RESP_OKAY;
    case (r_state)
      IDLE: begin
        s_axi_awready = r_rst_done;
        if (s_axi_awvalid && r_rst_done) w_state_next = DATA;
      end
      DATA: begin
        s_axi_wready = mem_ready || r_err;
        if (s_axi_wvalid && s_axi_wready && w_last_beat) w_state_next = RESP;
      end
      RESP: begin
        s_axi_bvalid = 1'b1;
        s_axi_bresp  = (r_err || w_wlast_mm) ? RESP_SLVERR : RESP_OKAY;
        if (s_axi_bready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_aw_hs) begin
      r_addr     <= s_axi_awaddr;
      r_len      <= s_axi_awlen;
      r_size     <= s_axi_awsize;
      r_burst    <= s_axi_awburst;
      r_beat_cnt <= '0;
      r_err      <= w_aw_err;
    end else if (w_w_hs) begin
      r_addr     <= w_next_addr;
      r_beat_cnt <= r_beat_cnt + 8'd1;
    end
  end

`ifdef AXI_WR_SINK_WLAST_CHECK_EN
  logic r_wlast_mm;

  // Sticky: early wlast or missing wlast on the counted last beat
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wlast_mm <= 1'b0;
    end else if (w_aw_hs) begin
      r_wlast_mm <= 1'b0;
    end else if (w_w_hs && (s_axi_wlast != w_last_beat)) begin
      r_wlast_mm <= 1'b1;
    end
  end

  assign w_wlast_mm = r_wlast_mm;
`else
  logic w_unused_wlast;
  assign w_unused_wlast = s_axi_wlast;
  assign w_wlast_mm     = 1'b0;
`endif

  axi_beat_addr_next #(
    .AW (AW)
  ) u_addr_next (
    .addr      (r_addr),
    .size      (r_size),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (w_next_addr)
  );

  assign mem_we    = w_w_hs && !r_err;
  assign mem_addr  = r_addr;
  assign mem_wdata = s_axi_wdata;
  assign mem_wstrb = s_axi_wstrb;

endmodule

`default_nettype wire

// File: doc/axi_wr_mem_sink.md
# axi_wr_mem_sink

AXI4 write-side slave endpoint that sits directly downstream of the slave write channel. It consumes one AW burst descriptor and its W beats, expands the burst into one per-beat byte address for each FIXED, INCR or WRAP beat, and drives a simple single-port memory write interface with backpressure. It returns a single B response per burst. One burst is in flight at a time; the block has no ID reordering.

## Interface
- AW, default 32: address width
- DW, default 64: data width; strobe width is DW/8
- clk  in  1: global clock
- resetn  in  1: asynchronous, active-low reset
- s_axi_awaddr  in  AW: burst start address
- s_axi_awlen  in  8: beats minus one
- s_axi_awsize  in  3: log2 bytes per beat
- s_axi_awburst  in  2: 00 FIXED, 01 INCR, 10 WRAP, 11 reserved
- s_axi_awvalid  in  1: AW valid
- s_axi_awready  out  1: AW ready
- s_axi_wdata  in  DW: beat data
- s_axi_wstrb  in  DW/8: byte strobes
- s_axi_wlast  in  1: last-beat flag
- s_axi_wvalid  in  1: W valid
- s_axi_wready  out  1: W ready
- s_axi_bresp  out  2: 00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1: response valid
- s_axi_bready  in  1: response ready
- mem_we  out  1: memory write strobe
- mem_addr  out  AW: beat byte address
- mem_wdata  out  DW: equals s_axi_wdata
- mem_wstrb  out  DW/8: equals s_axi_wstrb
- mem_ready  in  1: memory accepts a write this cycle

## Operation
- State machine: IDLE → DATA on an AW handshake. DATA → RESP on the W handshake of the final counted beat. RESP → IDLE on a B handshake.
- s_axi_awready = IDLE && rst_done. rst_done is a flop that resets to 0 and is set on the first clock edge after resetn deasserts.
- On the AW handshake the block latches addr, len, size and burst, clears beat_cnt, and computes err.
- err is set when any of the following hold:
  - burst = 11
  - awsize > log2(DW/8)
  - burst is WRAP and len is not one of 1, 3, 7, 15
- s_axi_wready = DATA && (mem_ready || err).
- mem_we = s_axi_wvalid && s_axi_wready && !err. This is combinational in the handshake cycle.
- mem_addr = the current beat address register.
- Beat address rules, with bytes = 1<<size:
  - The first beat uses the unaligned awaddr.
  - FIXED: the address is held for every beat.
  - INCR: next = (addr & ~(bytes-1)) + bytes. The result wraps modulo 2^AW. 4 KB crossing is not checked.
  - WRAP: L = (len+1)<<size and base = addr & ~(L-1). next = base | ((addr + bytes) & (L-1)).
- beat_cnt is 8 bits and increments on each W handshake. The final beat is the one where beat_cnt == len.
- Response: bresp = SLVERR if err, or if a wlast mismatch was recorded (see Configuration). Otherwise bresp = OKAY. s_axi_bvalid is high throughout RESP.

## Timing
- Reset values: awready 0, wready 0, bvalid 0, bresp 00, mem_we 0, mem_addr 0, state IDLE, beat_cnt 0.
- AW handshake at edge N: wready can assert in cycle N+1.
- Each beat takes one cycle when wvalid and mem_ready are both held high.
- Final-beat handshake at edge M: bvalid is high from cycle M+1.
- B handshake at edge K: awready is high again in cycle K+1. Minimum burst turnaround is therefore len+3 cycles.
- bvalid and bresp stay stable until bready is sampled high.
- W beats presented while the block is in IDLE or RESP are not accepted (wready = 0).
- Reset asserted mid-burst returns the block to IDLE immediately. No response is produced for the aborted burst, and mem_we drops asynchronously.

## Configuration
- AXI_WR_SINK_WLAST_CHECK_EN defined:
  - A beat with wlast = 1 before the counted final beat, or wlast = 0 on the counted final beat, sets a sticky mismatch flag.
  - The mismatch flag forces bresp = SLVERR.
  - The beat count alone still terminates the burst.
- AXI_WR_SINK_WLAST_CHECK_EN undefined: wlast is ignored entirely.

## Structure
- Package axi_wr_pkg holds:
  - burst encodings: BURST_FIXED, BURST_INCR, BURST_WRAP
  - RESP_OKAY, RESP_SLVERR
  - the wr_sink_state_e enum (IDLE, DATA, RESP)
- Sub-module axi_beat_addr_next: purely combinational (addr, size, len, burst) → next address. It is shared with the future read-side sink.

## Test plan
- INCR, awaddr 0x1000, len 3, size 3, mem_ready = 1 → mem_addr 0x1000, 0x1008, 0x1010, 0x1018 on consecutive cycles; bresp OKAY.
- Unaligned INCR, awaddr 0x1003, len 1, size 2 → mem_addr 0x1003, then 0x1004.
- WRAP, awaddr 0x2018, len 3, size 3 → mem_addr 0x2018, 0x2000, 0x2008, 0x2010.
- awburst 11, len 1 → two beats accepted with mem_we never high; bresp SLVERR.
- mem_ready held low for 3 cycles mid-burst → wready low for exactly those cycles; no beat lost or duplicated; bvalid held until bready.
- With AXI_WR_SINK_WLAST_CHECK_EN, len 2 and wlast on beat 1 → three beats written; bresp SLVERR. Reset asserted during beat 1 → awready 0 while in reset, then 1 the cycle after rst_done is set.
